// File: rtl/uart_word_loader.sv
// uart_word_loader: turns the UART receiver's byte strobe into word writes for
// program download. The stream is a 16-bit little-endian word count N followed
// by N little-endian 32-bit words, each written to consecutive word addresses
// starting at BASE_ADDR.
// Optional build macro: UART_LOADER_CHECKSUM_EN adds a trailing XOR check byte
// that covers every accepted byte, header included.
//
//   state   | meaning
//   --------+------------------------------------------------------------
//   S_IDLE  | waiting for the low byte of the word count
//   S_HDR1  | waiting for the high byte of the word count
//   S_DATA  | assembling data words, one write per 4 bytes
//   S_CHECK | waiting for the XOR check byte (checksum build only)
//   S_DONE  | load completed, sticky until i_Clear or reset
//   S_ERROR | timeout or bad checksum, sticky until i_Clear or reset

module uart_word_loader #(
    parameter int                ADDR_W       = 32,
    parameter logic [ADDR_W-1:0] BASE_ADDR    = '0,
    parameter int                TIMEOUT_CLKS = 1000000
) (
    input  logic              i_Clock,
    input  logic              i_Rst_n,
    input  logic              i_Enable,
    input  logic              i_Clear,
    input  logic              i_Rx_DV,
    input  logic [7:0]        i_Rx_Byte,
    output logic              o_Mem_We,
    output logic [ADDR_W-1:0] o_Mem_Addr,
    output logic [31:0]       o_Mem_Wdata,
    output logic              o_Busy,
    output logic              o_Done,
    output logic              o_Error
);

    // Idle timer counts down from TIMEOUT_CLKS-1 after each accepted byte;
    // hitting zero with no byte on that cycle is the expiry.
    localparam int TW = (TIMEOUT_CLKS > 1) ? $clog2(TIMEOUT_CLKS) : 1;
    localparam logic [TW-1:0] TIMER_LOAD = (TIMEOUT_CLKS > 0) ? TW'(TIMEOUT_CLKS - 1) : '0;
    localparam bit TIMEOUT_ON = (TIMEOUT_CLKS > 0);

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_HDR1  = 3'd1,
        S_DATA  = 3'd2,
        S_DONE  = 3'd3,
`ifdef UART_LOADER_CHECKSUM_EN
        S_ERROR = 3'd4,
        S_CHECK = 3'd5
`else
        S_ERROR = 3'd4
`endif
    } state_t;

    state_t      state;
    logic [15:0] words_left;
    logic [1:0]  byte_idx;
    logic [31:0] shift_reg;
    logic [TW-1:0] idle_timer;
`ifdef UART_LOADER_CHECKSUM_EN
    logic [7:0]  xor_sum;
`endif

    logic accept;
    logic timed;
    logic expired;

    // Byte qualification and timeout expiry; an accepted byte always beats expiry.
    always_comb begin
        accept  = i_Rx_DV && i_Enable;
        timed   = (state == S_HDR1) || (state == S_DATA)
`ifdef UART_LOADER_CHECKSUM_EN
                  || (state == S_CHECK)
`endif
                  ;
        expired = TIMEOUT_ON && timed && !accept && (idle_timer == '0);
    end

    // Load FSM with registered outputs, address stepping and idle timer.
    always_ff @(posedge i_Clock or negedge i_Rst_n) begin
        if (!i_Rst_n) begin
            state       <= S_IDLE;
            words_left  <= '0;
            byte_idx    <= '0;
            shift_reg   <= '0;
            idle_timer  <= TIMER_LOAD;
            o_Mem_We    <= 1'b0;
            o_Mem_Addr  <= BASE_ADDR;
            o_Mem_Wdata <= '0;
            o_Busy      <= 1'b0;
            o_Done      <= 1'b0;
            o_Error     <= 1'b0;
`ifdef UART_LOADER_CHECKSUM_EN
            xor_sum     <= '0;
`endif
        end else begin
            o_Mem_We <= 1'b0;
            // Address advances on the cycle after each write strobe.
            if (o_Mem_We)
                o_Mem_Addr <= o_Mem_Addr + ADDR_W'(4);

            if (i_Clear) begin
                // Clear drops any simultaneous byte; an in-flight strobe is already on the bus.
                state      <= S_IDLE;
                words_left <= '0;
                byte_idx   <= '0;
                idle_timer <= TIMER_LOAD;
                o_Mem_Addr <= BASE_ADDR;
                o_Busy     <= 1'b0;
                o_Done     <= 1'b0;
                o_Error    <= 1'b0;
`ifdef UART_LOADER_CHECKSUM_EN
                xor_sum    <= '0;
`endif
            end else begin
                if (accept)
                    idle_timer <= TIMER_LOAD;
                else if (timed && idle_timer != '0)
                    idle_timer <= idle_timer - TW'(1);

                if (expired) begin
                    state   <= S_ERROR;
                    o_Error <= 1'b1;
                    o_Busy  <= 1'b0;
                    o_Done  <= 1'b0;
                end else if (accept) begin
`ifdef UART_LOADER_CHECKSUM_EN
                    if (state == S_IDLE)
                        xor_sum <= i_Rx_Byte;
                    else if (timed)
                        xor_sum <= xor_sum ^ i_Rx_Byte;
`endif
                    case (state)
                        S_IDLE: begin
                            words_left[7:0] <= i_Rx_Byte;
                            o_Busy          <= 1'b1;
                            state           <= S_HDR1;
                        end
                        S_HDR1: begin
                            words_left[15:8] <= i_Rx_Byte;
                            byte_idx         <= '0;
                            if ({i_Rx_Byte, words_left[7:0]} == 16'd0) begin
`ifdef UART_LOADER_CHECKSUM_EN
                                state  <= S_CHECK;
`else
                                state  <= S_DONE;
                                o_Done <= 1'b1;
                                o_Busy <= 1'b0;
`endif
                            end else begin
                                state <= S_DATA;
                            end
                        end
                        S_DATA: begin
                            shift_reg[{byte_idx, 3'b000} +: 8] <= i_Rx_Byte;
                            byte_idx <= byte_idx + 2'd1;
                            if (byte_idx == 2'd3) begin
                                o_Mem_We    <= 1'b1;
                                o_Mem_Wdata <= {i_Rx_Byte, shift_reg[23:0]};
                                words_left  <= words_left - 16'd1;
                                if (words_left == 16'd1) begin
`ifdef UART_LOADER_CHECKSUM_EN
                                    state  <= S_CHECK;
`else
                                    state  <= S_DONE;
                                    o_Done <= 1'b1;
                                    o_Busy <= 1'b0;
`endif
                                end
                            end
                        end
`ifdef UART_LOADER_CHECKSUM_EN
                        S_CHECK: begin
                            o_Busy <= 1'b0;
                            if (i_Rx_Byte == xor_sum) begin
                                state  <= S_DONE;
                                o_Done <= 1'b1;
                            end else begin
                                state   <= S_ERROR;
                                o_Error <= 1'b1;
                            end
                        end
`endif
                        default: ;
                    endcase
                end
            end
        end
    end

endmodule
